pwm_update_ctrl: RTL and testbench

Timebase and threshold-update controller for a bank of `pwm` channels. It owns the shared free-running counter and its `overflow` strobe, accepts threshold writes from the register interface over a valid/ready handshake, and holds them in per-channel shadow registers. Each pending value is committed to its channel's `set_thres` on the next period boundary, so every PWM period uses one consistent threshold and updates are glitch-free.

---
 rtl/pwm_update_ctrl.sv | 136 +++++++++++++
 tb/tb_pwm_update_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_update_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_update_ctrl
// Shared timebase and glitch-free threshold-update controller for a bank of
// pwm channels. A free-running counter counts 0..per_q and strobes overflow on
// its last cycle. Threshold writes arrive over a valid/ready handshake, land in
// per-channel shadow registers, and are committed to the channels (set_thres)
// on the next period boundary so each period sees one consistent threshold.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   enable     - run timebase; low holds counter at 0
//   period     - requested top count (period length = period+1 cycles)
//   wr_valid   - threshold write request
//   wr_ready   - write can be accepted this cycle
//   wr_chan    - target channel of the write
//   wr_thres   - new threshold value
//   counter    - shared counter for all pwm instances
//   overflow   - last cycle of the current period
//   new_thres  - shadow values, channel i at [i*pwm_width +: pwm_width]
//   set_thres  - per-channel commit strobe (coincides with overflow)
//   pending    - shadow holds a value not yet committed
// -----------------------------------------------------------------------------
module pwm_update_ctrl #(
  parameter int pwm_width = 16,
  parameter int channels  = 4,
  parameter int chan_w    = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [pwm_width-1:0]          period,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [chan_w-1:0]             wr_chan,
  input  logic [pwm_width-1:0]          wr_thres,
  output logic [pwm_width-1:0]          counter,
  output logic                          overflow,
  output logic [channels*pwm_width-1:0] new_thres,
  output logic [channels-1:0]           set_thres,
  output logic [channels-1:0]           pending
);

  localparam int unsigned chan_count = channels;

  logic [pwm_width-1:0] per_q;
  logic [pwm_width-1:0] shadow [channels];
  logic                 in_range;
  logic                 accept;
  logic [channels-1:0]  wr_hit;

  // ---------------------------------------------------------------------------
  // Timebase
  // ---------------------------------------------------------------------------
  assign overflow = enable && (counter == per_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q   <= '0;
      counter <= '0;
    end else begin
      // The active period only changes at a boundary (or while idle), so a
      // running period is never stretched or cut short.
      if (!enable || overflow) begin
        per_q <= period;
      end
      if (!enable || overflow) begin
        counter <= '0;
      end else begin
        counter <= counter + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write handshake
  // ---------------------------------------------------------------------------
  // Out-of-range channels are always "ready" so a stray write never stalls
  // the register interface; the data is simply dropped.
  assign in_range = ({{(32-chan_w){1'b0}}, wr_chan} < chan_count);
  assign wr_ready = in_range ? ~pending[wr_chan] : 1'b1;
  assign accept   = wr_valid && wr_ready;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < channels; i++) begin
      wr_hit[i] = accept && in_range && (wr_chan == chan_w'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Commit and shadow storage
  // ---------------------------------------------------------------------------
  // A channel commits when the period ends with its value pending. Because
  // wr_ready is low while pending, a commit and a new accept can never hit the
  // same channel in one cycle; an accept in an overflow cycle therefore waits
  // for the following boundary.
  assign set_thres = {channels{overflow}} & pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~set_thres) | wr_hit;
    end
  end

  // NOTE: the shadow array is reset explicitly because its contents are
  // visible on new_thres straight out of reset; a storage array that is never
  // observed before being written would not need it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < channels; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < channels; i++) begin
        if (wr_hit[i]) begin
          shadow[i] <= wr_thres;
        end
      end
    end
  end

  always_comb begin
    new_thres = '0;
    for (int i = 0; i < channels; i++) begin
      new_thres[i*pwm_width +: pwm_width] = shadow[i];
    end
  end

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_update_ctrl
// Scoreboard bench: the driver applies directed and random stimulus, asks a
// behavioural model for the response expected in that cycle and queues it; a
// monitor on the falling edge pops each entry and compares it to the DUT.
// A second instance with three channels exercises out-of-range writes.
// -----------------------------------------------------------------------------
module tb_pwm_update_ctrl;

  localparam int W = 16;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic [W-1:0]   period;
  logic           wr_valid;
  logic           wr_ready;
  logic [1:0]     wr_chan;
  logic [W-1:0]   wr_thres;
  logic [W-1:0]   counter;
  logic           overflow;
  logic [C*W-1:0] new_thres;
  logic [C-1:0]   set_thres;
  logic [C-1:0]   pending;

  // Three-channel instance: wr_chan=3 is out of range there.
  logic           w3_valid;
  logic           w3_ready;
  logic [1:0]     w3_chan;
  logic [W-1:0]   w3_counter;
  logic           w3_overflow;
  logic [3*W-1:0] w3_new_thres;
  logic [2:0]     w3_set_thres;
  logic [2:0]     w3_pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_update_ctrl #(.pwm_width(W), .channels(C)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan),
    .wr_thres(wr_thres), .counter(counter), .overflow(overflow),
    .new_thres(new_thres), .set_thres(set_thres), .pending(pending)
  );

  pwm_update_ctrl #(.pwm_width(W), .channels(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
    .wr_valid(w3_valid), .wr_ready(w3_ready), .wr_chan(w3_chan),
    .wr_thres(16'hBEEF), .counter(w3_counter), .overflow(w3_overflow),
    .new_thres(w3_new_thres), .set_thres(w3_set_thres), .pending(w3_pending)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: period position, active period length, and a list of
  // uncommitted writes per channel.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0]   counter;
    logic           overflow;
    logic [C-1:0]   pending;
    logic [C-1:0]   set_thres;
    logic [C*W-1:0] new_thres;
    logic           wr_ready;
  } exp_t;

  exp_t   sb[$];
  int     m_pos;        // position within the running period
  int     m_top;        // last position of the running period
  bit     m_pend [C];
  int     m_val  [C];
  bit     m_accepted;   // last driven cycle accepted the write
  bit     m_ovf;        // last driven cycle was a period boundary

  function automatic void model_reset();
    m_pos = 0;
    m_top = 0;
    for (int i = 0; i < C; i++) begin
      m_pend[i] = 1'b0;
      m_val[i]  = 0;
    end
  endfunction

  // Drive one clock cycle with the currently applied inputs.
  task automatic cycle();
    exp_t e;
    bit   boundary;
    bit   ready;
    if (!rst_n) model_reset();
    boundary = enable && (m_pos == m_top);
    ready    = (int'(wr_chan) >= C) || !m_pend[wr_chan];
    e.counter   = W'(m_pos);
    e.overflow  = boundary;
    e.wr_ready  = ready;
    e.pending   = '0;
    e.set_thres = '0;
    e.new_thres = '0;
    for (int i = 0; i < C; i++) begin
      e.pending[i]           = m_pend[i];
      e.set_thres[i]         = boundary && m_pend[i];
      e.new_thres[i*W +: W]  = W'(m_val[i]);
    end
    sb.push_back(e);
    m_ovf      = boundary;
    m_accepted = rst_n && wr_valid && ready;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      // Committed values leave the pending set at the boundary.
      if (boundary) for (int i = 0; i < C; i++) m_pend[i] = 1'b0;
      if (m_accepted && int'(wr_chan) < C) begin
        m_pend[wr_chan] = 1'b1;
        m_val[wr_chan]  = int'(wr_thres);
      end
      if (!enable || boundary) begin
        m_top = int'(period);
        m_pos = 0;
      end else begin
        m_pos = m_pos + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Hold a write until accepted; the model decides acceptance, the DUT's
  // wr_ready is compared against it by the monitor.
  task automatic write(input logic [1:0] ch, input logic [W-1:0] val);
    int guard = 0;
    wr_valid = 1'b1;
    wr_chan  = ch;
    wr_thres = val;
    do begin
      cycle();
      guard++;
    end while (!m_accepted && guard < 64);
    if (!m_accepted) check("write_timeout", 64'(guard), 64'(0));
    wr_valid = 1'b0;
  endtask

  task automatic wait_pos(input int pos);
    int guard = 0;
    while (m_pos != pos && guard < 64) begin
      cycle();
      guard++;
    end
    if (m_pos != pos) check("wait_pos_timeout", 64'(m_pos), 64'(pos));
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("counter",   64'(counter),   64'(e.counter));
      check("overflow",  64'(overflow),  64'(e.overflow));
      check("pending",   64'(pending),   64'(e.pending));
      check("set_thres", 64'(set_thres), 64'(e.set_thres));
      check("new_thres", 64'(new_thres), 64'(e.new_thres));
      check("wr_ready",  64'(wr_ready),  64'(e.wr_ready));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; enable = 1'b0; period = '0;
    wr_valid = 1'b0; wr_chan = '0; wr_thres = '0;
    w3_valid = 1'b0; w3_chan = '0;
    model_reset();
    #1;
    idle(3);
    rst_n = 1'b1;

    // Out-of-range write on the 3-channel instance is dropped, in-range lands.
    w3_valid = 1'b1; w3_chan = 2'd3;
    #1 check("oor_ready", 64'(w3_ready), 64'(1));
    @(posedge clk); #1;
    check("oor_pending", 64'(w3_pending), 64'(0));
    check("oor_shadow",  64'(w3_new_thres), 64'(0));
    w3_chan = 2'd1;
    @(posedge clk); #1;
    w3_valid = 1'b0;
    check("inr_pending", 64'(w3_pending), 64'(3'b010));
    check("inr_shadow",  64'(w3_new_thres), {16'h0, 16'h0, 16'h0, 16'hBEEF, 16'h0});

    // Basic timebase with period 4.
    period = 16'd4;
    idle(1);
    enable = 1'b1;
    idle(12);

    // Mid-period write, then a second write to the same channel that stalls.
    wait_pos(1);
    write(2'd2, 16'h0003);
    write(2'd2, 16'h0007);
    idle(6);

    // Write accepted in an overflow cycle commits one period later.
    wait_pos(4);
    write(2'd1, 16'h0011);
    idle(6);

    // Period change mid-period, then period 0.
    wait_pos(2);
    period = 16'd9;
    idle(20);
    period = 16'd0;
    idle(12);
    write(2'd3, 16'h00AA);
    idle(3);
    period = 16'd4;
    idle(6);

    // Pending value survives enable low and commits after re-enable.
    wait_pos(1);
    write(2'd0, 16'h1234);
    enable = 1'b0;
    idle(4);
    enable = 1'b1;
    idle(8);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      enable   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) period = W'($urandom_range(0, 7));
      wr_valid = $urandom_range(0, 2) == 0;
      wr_chan  = 2'($urandom_range(0, C - 1));
      wr_thres = W'($urandom);
      cycle();
    end
    wr_valid = 1'b0;
    enable   = 1'b1;
    period   = 16'd6;
    idle(10);

    // Reset mid-period with writes pending.
    wait_pos(2);
    write(2'd3, 16'h5555);
    write(2'd0, 16'h6666);
    rst_n  = 1'b0;
    enable = 1'b0;
    idle(2);
    rst_n  = 1'b1;
    idle(2);
    enable = 1'b1;
    idle(10);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) check("scoreboard_drain", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
